// File: rtl/gps_sample_buffer.sv
// gps_sample_buffer: synchronizes raw GPS front-end samples into a 16-deep FIFO feeding the SPI bridge
//   MCU_CLK_25_000 : sole clock, RESET_N : synchronous active-low reset
//   GPS_CLK, GPS_{I0,I1,Q0,Q1}_RAW : asynchronous front-end clock and sample bits
//   SAMPLE_ACK : pop pulse; GPS_{I0,I1,Q0,Q1} : queue head; DATAREADY : non-empty
//   LEVEL : occupancy; OVERFLOW / OVF_COUNT : sticky drop flag and saturating drop count
`timescale 1ns/1ps
module gps_sample_buffer #(
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 8
) (
  input  logic              MCU_CLK_25_000,
  input  logic              RESET_N,
  input  logic              GPS_CLK,
  input  logic              GPS_I0_RAW,
  input  logic              GPS_I1_RAW,
  input  logic              GPS_Q0_RAW,
  input  logic              GPS_Q1_RAW,
  input  logic              SAMPLE_ACK,
  output logic              GPS_I0,
  output logic              GPS_I1,
  output logic              GPS_Q0,
  output logic              GPS_Q1,
  output logic              DATAREADY,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVERFLOW,
  output logic [OVF_W-1:0]  OVF_COUNT
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic              s1_q, s2_q, s3_q;
  logic [3:0]        d1_q, d2_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [3:0]        mem_q [DEPTH];
  logic              push, pop, full, wr_en, drop;
  always_comb begin
    push      = s2_q & ~s3_q;
    pop       = SAMPLE_ACK & (level_q != '0);
    full      = level_q == (ADDR_W+1)'(DEPTH);
    // a pop in the same cycle frees the slot the push needs, so it is not an overflow
    wr_en     = push & (~full | pop);
    drop      = push & full & ~pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d   = level_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
    ovf_d     = ovf_q | drop;
    ovf_cnt_d = (drop && ovf_cnt_q != '1) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
    DATAREADY = level_q != '0;
    LEVEL     = level_q;
    OVERFLOW  = ovf_q;
    OVF_COUNT = ovf_cnt_q;
    {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1} = DATAREADY ? mem_q[rd_ptr_q] : 4'h0;
  end
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      d1_q      <= '0;
      d2_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      s1_q      <= GPS_CLK;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      d1_q      <= {GPS_I0_RAW, GPS_I1_RAW, GPS_Q0_RAW, GPS_Q1_RAW};
      d2_q      <= d1_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_N && wr_en) mem_q[wr_ptr_q] <= d2_q;
  end
endmodule
